// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Writeback stage of the pipeline. Picks the value to write back (load data,
// ALU result, SAD result or the jal link address), commits it to a 32-entry
// register file and serves two combinational read ports to the ID stage with
// same-cycle write-to-read bypass. A free-running counter records every
// committed write.
//
// Ports:
//   Clk                       system clock, all state changes on rising edge
//   Reset                     synchronous reset, active low
//   RegWrite_WB               write enable from MEM/WB
//   MemToReg_WB               select load data
//   SadSel_WB                 select SAD result (below MemToReg_WB)
//   jal_WB                    link write, overrides destination and data
//   RegDst1Result_WB          destination register index
//   ReadData_WB               load data
//   ALUResult_WB              ALU result
//   sadMUX_regwrite_value_WB  SAD unit result
//   PCPlus4_WB                return address for jal
//   ReadReg1 / ReadReg2       read port indices
//   ReadData1 / ReadData2     read port data
//   WriteData_WB              selected writeback value, for the forwarding unit
//   WriteCount                number of committed writes (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LINK_REG   = 31
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  RegWrite_WB,
    input  logic                  MemToReg_WB,
    input  logic                  SadSel_WB,
    input  logic                  jal_WB,
    input  logic [ADDR_WIDTH-1:0] RegDst1Result_WB,
    input  logic [DATA_WIDTH-1:0] ReadData_WB,
    input  logic [DATA_WIDTH-1:0] ALUResult_WB,
    input  logic [DATA_WIDTH-1:0] sadMUX_regwrite_value_WB,
    input  logic [DATA_WIDTH-1:0] PCPlus4_WB,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [DATA_WIDTH-1:0] WriteData_WB,
    output logic [31:0]           WriteCount
);

    localparam int                  NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LINK_IDX = ADDR_WIDTH'(LINK_REG);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [31:0]           write_count_r;

    logic [DATA_WIDTH-1:0] wdata_s;
    logic [ADDR_WIDTH-1:0] dest_s;
    logic                  we_s;
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;

    // Writeback value select; jal outranks load, load outranks SAD.
    always_comb begin
        wdata_s = ALUResult_WB;
        if (jal_WB) begin
            wdata_s = PCPlus4_WB;
        end else if (MemToReg_WB) begin
            wdata_s = ReadData_WB;
        end else if (SadSel_WB) begin
            wdata_s = sadMUX_regwrite_value_WB;
        end else begin
            wdata_s = ALUResult_WB;
        end
    end

    // Effective destination and write enable; register 0 never accepts a write
    // and writes are dropped while reset is held.
    always_comb begin
        dest_s = RegDst1Result_WB;
        if (jal_WB) begin
            dest_s = LINK_IDX;
        end else begin
            dest_s = RegDst1Result_WB;
        end
        we_s = Reset & (RegWrite_WB | jal_WB) & (dest_s != ZERO_IDX);
    end

    // Read port 1: zeroed during reset, bypassed from the write in flight.
    always_comb begin
        rd1_s = ZERO_DATA;
        if (!Reset) begin
            rd1_s = ZERO_DATA;
        end else if (ReadReg1 == ZERO_IDX) begin
            rd1_s = ZERO_DATA;
        end else if (we_s && (ReadReg1 == dest_s)) begin
            rd1_s = wdata_s;
        end else begin
            rd1_s = regs_r[ReadReg1];
        end
    end

    // Read port 2: same resolution as port 1, evaluated independently.
    always_comb begin
        rd2_s = ZERO_DATA;
        if (!Reset) begin
            rd2_s = ZERO_DATA;
        end else if (ReadReg2 == ZERO_IDX) begin
            rd2_s = ZERO_DATA;
        end else if (we_s && (ReadReg2 == dest_s)) begin
            rd2_s = wdata_s;
        end else begin
            rd2_s = regs_r[ReadReg2];
        end
    end

    // Register array and write counter; reset clears both and drops the write.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
            write_count_r <= 32'd0;
        end else begin
            if (we_s) begin
                regs_r[dest_s] <= wdata_s;
                write_count_r  <= write_count_r + 32'd1;
            end
        end
    end

    assign ReadData1    = rd1_s;
    assign ReadData2    = rd2_s;
    assign WriteData_WB = Reset ? wdata_s : ZERO_DATA;
    assign WriteCount   = write_count_r;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Table-driven bench for wb_regfile. Each record holds one cycle of inputs and
// the outputs expected during that cycle (before its rising edge). Expected
// values go into a scoreboard queue when the inputs are driven and are popped
// and compared once the combinational outputs have settled.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    typedef struct {
        logic        rst;
        logic        rw;
        logic        m2r;
        logic        sad;
        logic        jal;
        logic [4:0]  dst;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] sadv;
        logic [31:0] pc4;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_wd;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wd;
        logic [31:0] cnt;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        RegWrite_WB;
    logic        MemToReg_WB;
    logic        SadSel_WB;
    logic        jal_WB;
    logic [4:0]  RegDst1Result_WB;
    logic [31:0] ReadData_WB;
    logic [31:0] ALUResult_WB;
    logic [31:0] sadMUX_regwrite_value_WB;
    logic [31:0] PCPlus4_WB;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteData_WB;
    logic [31:0] WriteCount;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[15];

    wb_regfile dut (
        .Clk                      (Clk),
        .Reset                    (Reset),
        .RegWrite_WB              (RegWrite_WB),
        .MemToReg_WB              (MemToReg_WB),
        .SadSel_WB                (SadSel_WB),
        .jal_WB                   (jal_WB),
        .RegDst1Result_WB         (RegDst1Result_WB),
        .ReadData_WB              (ReadData_WB),
        .ALUResult_WB             (ALUResult_WB),
        .sadMUX_regwrite_value_WB (sadMUX_regwrite_value_WB),
        .PCPlus4_WB               (PCPlus4_WB),
        .ReadReg1                 (ReadReg1),
        .ReadReg2                 (ReadReg2),
        .ReadData1                (ReadData1),
        .ReadData2                (ReadData2),
        .WriteData_WB             (WriteData_WB),
        .WriteCount               (WriteCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %08h expected %08h", tag, what, act, exp);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge, queue the expectation,
    // compare after settling, then let the rising edge commit.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        @(negedge Clk);
        Reset                    = v.rst;
        RegWrite_WB              = v.rw;
        MemToReg_WB              = v.m2r;
        SadSel_WB                = v.sad;
        jal_WB                   = v.jal;
        RegDst1Result_WB         = v.dst;
        ReadData_WB              = v.rdata;
        ALUResult_WB             = v.alu;
        sadMUX_regwrite_value_WB = v.sadv;
        PCPlus4_WB               = v.pc4;
        ReadReg1                 = v.rr1;
        ReadReg2                 = v.rr2;
        e.rd1 = v.e_rd1;
        e.rd2 = v.e_rd2;
        e.wd  = v.e_wd;
        e.cnt = v.e_cnt;
        exp_q.push_back(e);
        #2;
        got = exp_q.pop_front();
        check(tag, "rd1", ReadData1, got.rd1);
        check(tag, "rd2", ReadData2, got.rd2);
        check(tag, "wd",  WriteData_WB, got.wd);
        check(tag, "cnt", WriteCount, got.cnt);
        @(posedge Clk);
    endtask

    initial begin
        vec_t v;
        //           rst  rw   m2r  sad  jal  dst    rdata         alu           sadv          pc4           rr1    rr2    e_rd1         e_rd2         e_wd          e_cnt
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,5'd12, 32'h0,        32'h7,        32'h0,        32'h0,        5'd12, 5'd12, 32'h0,        32'h0,        32'h0,        32'd0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd12, 32'h0,        32'h7,        32'h0,        32'h0,        5'd12, 5'd1,  32'h0,        32'h0,        32'h7,        32'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,5'd8,  32'h0,        32'h1234,     32'h0,        32'h0,        5'd8,  5'd9,  32'h1234,     32'h0,        32'h1234,     32'd0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd8,  32'h0,        32'h0,        32'h0,        32'h0,        5'd8,  5'd8,  32'h1234,     32'h1234,     32'h0,        32'd1};
        vecs[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,5'd9,  32'hDEADBEEF, 32'h0,        32'h55,       32'h0,        5'd9,  5'd8,  32'hDEADBEEF, 32'h1234,     32'hDEADBEEF, 32'd1};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,5'd10, 32'hDEADBEEF, 32'h0,        32'h55,       32'h0,        5'd9,  5'd10, 32'hDEADBEEF, 32'h55,       32'h55,       32'd2};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,5'd5,  32'h0,        32'h99,       32'h0,        32'h40,       5'd31, 5'd5,  32'h40,       32'h0,        32'h40,       32'd3};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd5,  32'h0,        32'h0,        32'h0,        32'h0,        5'd31, 5'd5,  32'h40,       32'h0,        32'h0,        32'd4};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,  32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'd4};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        5'd0,  5'd10, 32'h0,        32'h55,       32'h0,        32'd4};
        vecs[10] = '{1'b1,1'b1,1'b1,1'b0,1'b1,5'd3,  32'h111,      32'h0,        32'h0,        32'h80,       5'd31, 5'd3,  32'h80,       32'h0,        32'h80,       32'd4};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0,5'd8,  32'h0,        32'hAAAA,     32'h0,        32'h0,        5'd8,  5'd8,  32'hAAAA,     32'hAAAA,     32'hAAAA,     32'd5};
        vecs[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,5'd13, 32'h0,        32'h5,        32'h0,        32'h0,        5'd13, 5'd8,  32'h0,        32'h0,        32'h0,        32'd6};
        vecs[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0,5'd14, 32'h0,        32'h6,        32'h0,        32'h0,        5'd8,  5'd13, 32'h0,        32'h0,        32'h6,        32'd0};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd14, 32'h0,        32'h0,        32'h0,        32'h0,        5'd14, 5'd31, 32'h6,        32'h0,        32'h0,        32'd1};

        // Power-up reset held for two rising edges.
        Reset                    = 1'b0;
        RegWrite_WB              = 1'b0;
        MemToReg_WB              = 1'b0;
        SadSel_WB                = 1'b0;
        jal_WB                   = 1'b0;
        RegDst1Result_WB         = 5'd0;
        ReadData_WB              = 32'h0;
        ALUResult_WB             = 32'h0;
        sadMUX_regwrite_value_WB = 32'h0;
        PCPlus4_WB               = 32'h0;
        ReadReg1                 = 5'd0;
        ReadReg2                 = 5'd0;
        repeat (2) @(posedge Clk);

        // Every register reads zero after reset.
        for (int r = 1; r < 32; r++) begin
            v = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,32'h0,32'h0,32'h0,
                  5'(r),5'(32 - r),32'h0,32'h0,32'h0,32'd0};
            apply(v, $sformatf("clear%0d", r));
        end

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Counter wrap: preload the counter one short of rollover.
        #1;
        force dut.write_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.write_count_r;
        v = '{1'b1,1'b1,1'b0,1'b0,1'b0,5'd20,32'h0,32'h1,32'h0,32'h0,
              5'd20,5'd14,32'h1,32'h6,32'h1,32'hFFFF_FFFF};
        apply(v, "wrap_a");
        v = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd20,32'h0,32'h0,32'h0,32'h0,
              5'd20,5'd0,32'h1,32'h0,32'h0,32'd0};
        apply(v, "wrap_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
